// File: rtl/sel_regbank.sv
// sel_regbank: register bank with per-register valid scoreboard, two registered read ports and first-invalid encoder
module sel_regbank #(
   parameter int WIDTH    = 20,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 0,
   localparam int SELW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [SELW-1:0]  wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             inv_en,
   input  logic [SELW-1:0]  inv_sel,
   input  logic [SELW-1:0]  rd_sel_a,
   input  logic [SELW-1:0]  rd_sel_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_vld_a,
   output logic             rd_vld_b,
   output logic [NREG-1:0]  valid,
   output logic [SELW-1:0]  first_inv,
   output logic             any_inv
);
   logic [WIDTH-1:0] mem [NREG];
   logic [NREG-1:0]  valid_nxt;
   logic [WIDTH-1:0] rd_nxt_a, rd_nxt_b;
   logic             wr_ok, inv_ok;

   // a hardwired-zero register 0 swallows both writes and invalidates, so mem[0] stays 0 and valid[0] stays 1
   assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_sel  == '0);
   assign inv_ok = inv_en && !(ZERO_REG != 0 && inv_sel == '0);

   // post-edge valid vector; the invalidate is applied last so it wins a same-index collision
   always_comb begin
      valid_nxt = valid;
      if (wr_ok) valid_nxt[wr_sel] = 1'b1;
      if (inv_ok) valid_nxt[inv_sel] = 1'b0;
   end

   // read muxes with write-through bypass of same-cycle write data
   always_comb begin
      rd_nxt_a = (wr_ok && wr_sel == rd_sel_a) ? wr_data : mem[rd_sel_a];
      rd_nxt_b = (wr_ok && wr_sel == rd_sel_b) ? wr_data : mem[rd_sel_b];
   end

   // register storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < NREG; i++) mem[i] <= '0;
      else if (wr_ok) mem[wr_sel] <= wr_data;
   end

   // valid scoreboard and registered read ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid     <= '1;
         rd_data_a <= '0;
         rd_data_b <= '0;
         rd_vld_a  <= 1'b1;
         rd_vld_b  <= 1'b1;
      end else begin
         valid     <= valid_nxt;
         rd_data_a <= rd_nxt_a;
         rd_data_b <= rd_nxt_b;
         rd_vld_a  <= valid_nxt[rd_sel_a];
         rd_vld_b  <= valid_nxt[rd_sel_b];
      end
   end

   // priority encoder: scanning downward leaves the lowest invalid index as the final assignment
   always_comb begin
      first_inv = '0;
      any_inv   = 1'b0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            first_inv = SELW'(i);
            any_inv   = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sel_regbank.sv
// tb_sel_regbank: scoreboard bench for sel_regbank, plus a ZERO_REG=1 instance sharing the same stimulus
module tb_sel_regbank;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0, inv_en = 1'b0;
   logic [4:0]  wr_sel = '0, inv_sel = '0, rd_sel_a = '0, rd_sel_b = '0;
   logic [19:0] wr_data = '0;
   logic [19:0] rd_data_a, rd_data_b, z_rd_data_a, z_rd_data_b;
   logic        rd_vld_a, rd_vld_b, z_rd_vld_a, z_rd_vld_b;
   logic [31:0] valid, z_valid;
   logic [4:0]  first_inv, z_first_inv;
   logic        any_inv, z_any_inv;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [19:0] da, db;
      logic        va, vb;
   } exp_t;
   exp_t q[$];

   logic [19:0] mem_m [32];
   logic [31:0] val_m;

   sel_regbank #(.WIDTH(20), .NREG(32), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .inv_en(inv_en), .inv_sel(inv_sel), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_vld_a(rd_vld_a), .rd_vld_b(rd_vld_b),
      .valid(valid), .first_inv(first_inv), .any_inv(any_inv)
   );

   sel_regbank #(.WIDTH(20), .NREG(32), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .inv_en(inv_en), .inv_sel(inv_sel), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b), .rd_vld_a(z_rd_vld_a), .rd_vld_b(z_rd_vld_b),
      .valid(z_valid), .first_inv(z_first_inv), .any_inv(z_any_inv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] enc_m(input logic [31:0] v);
      for (int i = 0; i < 32; i++) if (!v[i]) return {1'b1, 5'(i)};
      return 6'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem_m[i] = '0;
      val_m = '1;
   endtask

   task automatic set_in(input logic we, input logic [4:0] ws, input logic [19:0] wd,
                         input logic ie, input logic [4:0] is, input logic [4:0] ra, input logic [4:0] rb);
      wr_en = we; wr_sel = ws; wr_data = wd; inv_en = ie; inv_sel = is; rd_sel_a = ra; rd_sel_b = rb;
   endtask

   // drive one cycle: predict from the model, push, clock, pop and compare
   task automatic step(input string tag);
      exp_t e;
      logic [31:0] nv;
      logic [5:0] enc;
      nv = val_m;
      if (wr_en) nv[wr_sel] = 1'b1;
      if (inv_en) nv[inv_sel] = 1'b0;
      e.tag = tag;
      e.da = (wr_en && wr_sel == rd_sel_a) ? wr_data : mem_m[rd_sel_a];
      e.db = (wr_en && wr_sel == rd_sel_b) ? wr_data : mem_m[rd_sel_b];
      e.va = nv[rd_sel_a];
      e.vb = nv[rd_sel_b];
      if (wr_en) mem_m[wr_sel] = wr_data;
      val_m = nv;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      enc = enc_m(val_m);
      chk({e.tag, ".da"}, 32'(rd_data_a), 32'(e.da));
      chk({e.tag, ".db"}, 32'(rd_data_b), 32'(e.db));
      chk({e.tag, ".va"}, 32'(rd_vld_a), 32'(e.va));
      chk({e.tag, ".vb"}, 32'(rd_vld_b), 32'(e.vb));
      chk({e.tag, ".valid"}, valid, val_m);
      chk({e.tag, ".first_inv"}, 32'(first_inv), 32'(enc[4:0]));
      chk({e.tag, ".any_inv"}, 32'(any_inv), 32'(enc[5]));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, ".da"}, 32'(rd_data_a), 32'h0);
      chk({tag, ".db"}, 32'(rd_data_b), 32'h0);
      chk({tag, ".va"}, 32'(rd_vld_a), 32'h1);
      chk({tag, ".vb"}, 32'(rd_vld_b), 32'h1);
      chk({tag, ".valid"}, valid, 32'hFFFF_FFFF);
      chk({tag, ".first_inv"}, 32'(first_inv), 32'h0);
      chk({tag, ".any_inv"}, 32'(any_inv), 32'h0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("rst");
      chk("rst.z_valid", z_valid, 32'hFFFF_FFFF);
      #3 rst_n = 1'b1;

      set_in(1, 5'd5, 20'hABCDE, 0, 0, 0, 0); step("wr5");
      set_in(0, 0, 0, 0, 0, 5'd5, 0);         step("rd5");
      chk("rd5.const", 32'(rd_data_a), 32'h000ABCDE);
      chk("rd5.vld", 32'(rd_vld_a), 32'h1);

      set_in(1, 5'd7, 20'h12345, 0, 0, 0, 5'd7); step("byp7");
      chk("byp7.const", 32'(rd_data_b), 32'h00012345);

      set_in(0, 0, 0, 1, 5'd9, 0, 0); step("inv9");
      set_in(0, 0, 0, 1, 5'd3, 0, 0); step("inv3");
      chk("inv.v9", 32'(valid[9]), 32'h0);
      chk("inv.v3", 32'(valid[3]), 32'h0);
      chk("inv.first", 32'(first_inv), 32'd3);
      chk("inv.any", 32'(any_inv), 32'h1);
      set_in(1, 5'd3, 20'h00333, 0, 0, 0, 0); step("wr3");
      chk("wr3.first", 32'(first_inv), 32'd9);
      set_in(1, 5'd9, 20'h00999, 0, 0, 0, 0); step("wr9");
      chk("wr9.any", 32'(any_inv), 32'h0);
      chk("wr9.first", 32'(first_inv), 32'd0);

      set_in(1, 5'd12, 20'h00FFF, 1, 5'd12, 5'd12, 0); step("coll12");
      set_in(0, 0, 0, 0, 0, 5'd12, 0);                 step("rd12");
      chk("rd12.data", 32'(rd_data_a), 32'h00000FFF);
      chk("rd12.vld", 32'(rd_vld_a), 32'h0);
      set_in(1, 5'd4, 20'h44444, 1, 5'd6, 0, 0); step("wr4inv6");
      set_in(0, 0, 0, 0, 0, 5'd4, 5'd6);         step("rd4_6");
      chk("rd4_6.v4", 32'(valid[4]), 32'h1);
      chk("rd4_6.v6", 32'(valid[6]), 32'h0);
      set_in(0, 0, 0, 0, 0, 5'd5, 5'd5); step("same5");
      chk("same5.eq", 32'(rd_data_a), 32'(rd_data_b));

      set_in(1, 5'd0, 20'hFFFFF, 1, 5'd0, 5'd0, 5'd0); step("z0");
      chk("z0.byp_data", 32'(z_rd_data_a), 32'h0);
      chk("z0.byp_vld", 32'(z_rd_vld_a), 32'h1);
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0); step("z0rd");
      chk("z0rd.data", 32'(z_rd_data_a), 32'h0);
      chk("z0rd.vld", 32'(z_rd_vld_b), 32'h1);
      chk("z0rd.valid0", 32'(z_valid[0]), 32'h1);

      for (int n = 0; n < 60; n++) begin
         set_in(1'($urandom_range(0, 1)), 5'($urandom), 20'($urandom), 1'($urandom_range(0, 3) == 0),
                5'($urandom), 5'($urandom), 5'($urandom));
         step($sformatf("rnd%0d", n));
      end

      for (int i = 0; i < 31; i++) begin
         set_in(1, 5'(i), 20'(32'h1111 * (i + 1)), 0, 0, 0, 0);
         step($sformatf("pop%0d", i));
      end
      set_in(0, 0, 0, 1, 5'd31, 5'd2, 5'd3); step("inv31");
      chk("inv31.first", 32'(first_inv), 32'd31);
      set_in(1, 5'd2, 20'hBEEF1, 1, 5'd4, 5'd2, 5'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outs("arst");
      @(posedge clk);
      #1;
      chk_reset_outs("arst_edge");
      model_reset();
      set_in(0, 0, 0, 0, 0, 5'd2, 5'd3);
      #2 rst_n = 1'b1;
      step("post_rst");
      chk("post_rst.r2", 32'(rd_data_a), 32'h0);
      set_in(0, 0, 0, 0, 0, 5'd10, 5'd30); step("post_rst2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
